pll_reset_ctrl: RTL

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 35 +++
 rtl/pll_reset_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_pkg.sv
// ---------------------------------------------------------------------------
// pll_reset_pkg
// Shared definitions for the PLL reset sequencer: state encoding, status
// counter widths and a helper that sizes the shared cycle counter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package pll_reset_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;
  localparam logic [LOSS_W-1:0]  LOSS_SAT  = '1;

  // The cycle counter only has to reach (largest parameter - 1) before a
  // state change clears it, so clog2 of the largest parameter is enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer with asynchronous active-low clear.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low clear (both stages go to 0)
//   d     : asynchronous input bus
//   q     : synchronized output, two clk edges of latency
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl
// Sequences a PLL out of reset: pulses pll_rst, waits for lock (with
// timeout and retry), requires a window of stable lock, then releases the
// system reset. Loss of lock in RUN restarts the whole sequence.
//
// Ports:
//   refclk        : free-running reference clock (also feeds the PLL)
//   rst_n         : asynchronous active-low reset, release synchronized
//   locked        : PLL lock flag, asynchronous to refclk
//   pll_rst       : active-high PLL reset, high in PLL_RST (and FAIL)
//   sys_rst_n     : registered active-low system reset, high only in RUN
//   ready         : high only in RUN
//   fail          : high only in FAIL
//   state         : current FSM state (debug / checker visibility)
//   retry_cnt     : lock timeouts since reset, saturating at 15
//   lock_loss_cnt : RUN-to-lock-loss events since reset, saturating at 255
//
// Build option:
//   PLL_RESET_CTRL_RETRY_LIMIT_EN : when defined, a timeout with retry_cnt
//   already at MAX_RETRIES enters a sticky FAIL state. When undefined,
//   FAIL is unreachable, fail is tied low and retries never stop.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 27000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 7
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               locked,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  lock_loss_cnt
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                   STABLE_CYCLES);

  // Terminal counts. The counter reads 0 in the first cycle of a state, so
  // a state lasting N cycles leaves when the counter shows N-1.
  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'((PLL_RST_CYCLES > 1) ? PLL_RST_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((LOCK_TIMEOUT_CYCLES > 1) ? LOCK_TIMEOUT_CYCLES - 1 : 0);
  // The lk=1 sample that moves WAIT_LOCK into STABLE is the first of the
  // consecutive high samples, so STABLE itself needs STABLE_CYCLES-1 more.
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'((STABLE_CYCLES > 2) ? STABLE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  // Elaboration-time sanity check on the configuration.
  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || STABLE_CYCLES < 1 ||
      MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_param
    $error("pll_reset_ctrl: parameter out of range");
  end

  // Synchronizers: lock flag and reset release.
  logic lk;
  logic run_en;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lk)
  );

  sync_2ff #(.WIDTH(1)) u_rst_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (run_en)
  );

  // State and counters.
  state_t             state_q;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q;
  logic [LOSS_W-1:0]  loss_q;
  logic               retry_inc;
  logic               loss_inc;

  logic               pll_rst_q;
  logic               sys_rst_n_q;
  logic               ready_q;

  always_comb begin
    state_next = state_q;
    retry_inc  = 1'b0;
    loss_inc   = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lk) begin
          state_next = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
`ifdef PLL_RESET_CTRL_RETRY_LIMIT_EN
          if (retry_q == RETRY_W'(MAX_RETRIES)) begin
            state_next = ST_FAIL;
          end else begin
            state_next = ST_PLL_RST;
            retry_inc  = 1'b1;
          end
`else
          state_next = ST_PLL_RST;
          retry_inc  = 1'b1;
`endif
        end
      end
      ST_STABLE: begin
        if (!lk) state_next = ST_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!lk) begin
          state_next = ST_PLL_RST;
          loss_inc   = 1'b1;
        end
      end
      ST_FAIL: begin
`ifdef PLL_RESET_CTRL_RETRY_LIMIT_EN
        state_next = ST_FAIL;
`else
        state_next = ST_PLL_RST;
`endif
      end
      default: state_next = ST_PLL_RST;
    endcase
  end

  // Held at reset values until the synchronized reset release arrives.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else if (!run_en) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q <= state_next;
      if (state_next != state_q) cnt_q <= '0;
      else if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      if (retry_inc && retry_q != RETRY_SAT) retry_q <= retry_q + 1'b1;
      if (loss_inc && loss_q != LOSS_SAT) loss_q <= loss_q + 1'b1;
      // Outputs are registered from the next state so they change on the
      // same edge as the state and cannot glitch on a multi-bit decode.
      pll_rst_q   <= (state_next == ST_PLL_RST) || (state_next == ST_FAIL);
      sys_rst_n_q <= (state_next == ST_RUN);
      ready_q     <= (state_next == ST_RUN);
    end
  end

`ifdef PLL_RESET_CTRL_RETRY_LIMIT_EN
  logic fail_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) fail_q <= 1'b0;
    else if (!run_en) fail_q <= 1'b0;
    else fail_q <= (state_next == ST_FAIL);
  end

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule
